// File: rtl/alu_serial_sequencer.sv
// ---------------------------------------------------------------------------
// alu_serial_sequencer
//
// Bit-serial ALU. Accepts one operation while idle, then processes one bit
// per clock, LSB first, for WIDTH cycles. After that it spends one cycle in
// DONE, where it presents a done pulse together with the new result and flags.
//
// Operation encoding (opcode):
//   [3] invert A, [2] invert B (this bit also seeds the carry, which gives
//   A - B for opcode 0110), [1:0] = 00 AND, 01 OR, 10 ADD, 11 pass B.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   start      operation request, sampled only while ready
//   a, b       operands (WIDTH bits)
//   opcode     operation select (4 bits)
//   ready      high in IDLE
//   busy       high in RUN
//   done       one-cycle pulse in DONE
//   result     last completed result; held until the next DONE or reset
//   carry_out  final carry of the last completed operation
//   zero       result == 0
//   overflow   signed overflow of the last ADD-class operation, else 0
// ---------------------------------------------------------------------------
module alu_serial_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              zero_q, zero_d;
    logic              overflow_q, overflow_d;

    // Per-bit datapath for the bit currently selected by the counter.
    logic              ai, bi, sum_bit, cnext, bit_out;
    logic [WIDTH-1:0]  shift_next;

    always_comb begin
        ai      = a_q[cnt_q] ^ op_q[3];
        bi      = b_q[cnt_q] ^ op_q[2];
        sum_bit = ai ^ bi ^ carry_q;
        cnext   = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        case (op_q[1:0])
            2'b00:   bit_out = ai & bi;
            2'b01:   bit_out = ai | bi;
            2'b10:   bit_out = sum_bit;
            default: bit_out = bi;
        endcase
        // LSB-first: each new bit enters at the top, so after WIDTH shifts
        // bit 0 has arrived at position 0.
        shift_next = {bit_out, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        shift_d     = shift_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = opcode;
                    cnt_d   = '0;
                    carry_d = opcode[2];
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cnext;
                shift_d = shift_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d     = DONE;
                    result_d    = shift_next;
                    carry_out_d = cnext;
                    zero_d      = (shift_next == '0);
                    // carry_q is the carry into the MSB, cnext the carry out of it.
                    overflow_d  = (op_q[1:0] == 2'b10) & (carry_q ^ cnext);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            shift_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            shift_q     <= shift_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_sequencer
//
// Scoreboard bench: the driver pushes the expected outcome of each accepted
// operation (from a word-level arithmetic model) into a queue; the monitor
// pops and compares on every done pulse, and also checks every cycle that
// exactly one of ready/busy/done is high and that result/flags only move at
// done or reset.
// ---------------------------------------------------------------------------
module tb_alu_serial_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   opcode;
    logic         ready, busy, done;
    logic [W-1:0] result;
    logic         carry_out, zero, overflow;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         z;
        logic         ov;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_cycles[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   done_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Word-level reference: invert operands, one full-width add seeded with
    // opcode[2]; overflow from operand/sum sign comparison.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic [3:0] op);
        exp_t         e;
        logic [W-1:0] ap, bp;
        logic [W:0]   full;
        ap   = op[3] ? ~ia : ia;
        bp   = op[2] ? ~ib : ib;
        full = {1'b0, ap} + {1'b0, bp} + {{W{1'b0}}, op[2]};
        case (op[1:0])
            2'b00:   e.res = ap & bp;
            2'b01:   e.res = ap | bp;
            2'b10:   e.res = full[W-1:0];
            default: e.res = bp;
        endcase
        e.co      = full[W];
        e.z       = (e.res == '0);
        e.ov      = (op[1:0] == 2'b10) && (ap[W-1] == bp[W-1]) && (full[W-1] != ap[W-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: sample #1 after each rising edge.
    initial begin
        logic [W+2:0] prev_out;
        logic         rst_at_edge;
        exp_t         e;
        prev_out = '0;
        forever begin
            @(posedge clk);
            rst_at_edge = rst;
            cyc++;
            #1;
            chk("state_onehot", {61'd0, ready, busy, done}, (ready + busy + done == 1) ? {61'd0, ready, busy, done} : 64'h1);
            if (!done && !rst_at_edge)
                chk("outputs_hold", {29'd0, result, carry_out, zero, overflow}, {29'd0, prev_out});
            if (done) begin
                done_count++;
                done_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result",    {32'd0, result}, {32'd0, e.res});
                    chk("carry_out", {63'd0, carry_out}, {63'd0, e.co});
                    chk("zero",      {63'd0, zero}, {63'd0, e.z});
                    chk("overflow",  {63'd0, overflow}, {63'd0, e.ov});
                    // done visible after the WIDTH-th edge following acceptance,
                    // i.e. WIDTH+1 edges counting the accepting edge itself.
                    chk("latency",   64'(cyc - e.acc_cyc), 64'(W));
                end
            end
            prev_out = {result, carry_out, zero, overflow};
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    // Present an operation with start=1 and return once it is accepted;
    // start is left high for the caller to drop.
    task automatic accept(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] op);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; opcode = op; start = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        e = model(ia, ib, op);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] op);
        accept(ia, ib, op);
        @(negedge clk);
        start = 1'b0;
        // scramble inputs: the operation in flight must not see them
        a = $urandom; b = $urandom; opcode = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; opcode = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {63'd0, ready}, 64'd1);
        chk("rst_outs",   {29'd0, busy, done, result, carry_out, zero, overflow}, 64'd0);
        rst = 1'b0;

        // Directed cases
        issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        drain();
        issue(32'd5, 32'd5, 4'b0110);
        drain();
        issue(32'hF0F0_F0F0, 32'h0F0F_0000, 4'b1100);
        drain();
        issue(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010);
        drain();
        issue(32'h8000_0000, 32'h8000_0000, 4'b0010);
        drain();
        issue(32'h1234_5678, 32'hCAFE_F00D, 4'b0011);
        drain();

        // Start pulses during RUN and operand change must not disturb the op
        d0 = done_count;
        accept(32'h0001_2345, 32'h0000_1111, 4'b0010);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 32'hDEAD_BEEF;
        repeat (16) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        chk("single_done", 64'(done_count - d0), 64'd1);

        // Reset in the middle of RUN aborts with no done pulse
        d0 = done_count;
        accept(32'hAAAA_5555, 32'h1357_9BDF, 4'b0010);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #2;
        chk("abort_ready", {63'd0, ready}, 64'd1);
        chk("abort_outs",  {29'd0, busy, done, result, carry_out, zero, overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", 64'(done_count - d0), 64'd0);
        issue(32'h0000_00FF, 32'h0000_0F00, 4'b0001);
        drain();

        // Two operations with start held high throughout
        accept(32'h0000_0010, 32'h0000_0020, 4'b0010);
        a = 32'hFFFF_0000; b = 32'h0000_FFFF; opcode = 4'b0001;
        @(negedge clk);
        wait_ready();
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e = model(32'hFFFF_0000, 32'h0000_FFFF, 4'b0001);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("b2b_spacing", 64'(done_cycles[$] - done_cycles[$-1]), 64'(W + 2));

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (i % 7 == 0) ra = '1;
            if (i % 5 == 0) rb = 32'h8000_0000;
            issue(ra, rb, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
